// File: rtl/moore_pattern_detector.sv
// ---------------------------------------------------------------------------
// moore_pattern_detector
//
// Parametrised Moore serial pattern detector. The state register holds the
// number of pattern bits currently matched (0..N_BITS). The next state is the
// KMP transition: the longest prefix of the pattern that is a suffix of
// (matched prefix + new bit). The pattern is runtime-loadable; a saturating
// counter tallies completed matches.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (state, pattern, counter)
//   In_Valid     In_Data is sampled this cycle
//   In_Data      serial input bit
//   Load_Pattern load Pattern into the pattern register, restart search
//   Pattern      new pattern, MSB is the first bit in time
//   Count_Clr    clear the match counter (wins over increment)
//   Out_State    current state (bits matched)
//   Out_Match    high while state == N_BITS
//   Match_Count  saturating match counter
// ---------------------------------------------------------------------------
module moore_pattern_detector #(
  parameter int unsigned         N_BITS      = 4,
  parameter logic [N_BITS-1:0]   PAT_DEFAULT = 4'b1011,
  parameter bit                  OVERLAP     = 1'b1,
  parameter int unsigned         CNT_W       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        In_Valid,
  input  logic                        In_Data,
  input  logic                        Load_Pattern,
  input  logic [N_BITS-1:0]           Pattern,
  input  logic                        Count_Clr,
  output logic [$clog2(N_BITS+1)-1:0] Out_State,
  output logic                        Out_Match,
  output logic [CNT_W-1:0]            Match_Count
);

  localparam int unsigned       ST_W = $clog2(N_BITS + 1);
  localparam logic [ST_W-1:0]   FULL = ST_W'(N_BITS);

  logic [N_BITS-1:0] pat_reg;
  logic [ST_W-1:0]   state;
  logic              match_r;
  logic [CNT_W-1:0]  cnt;

  // pattern bits in time order: pt[0] is the first bit expected
  logic [N_BITS-1:0] pt;
  // next state for every possible effective current state, given In_Data
  logic [ST_W-1:0]   kk [N_BITS+1];
  logic [ST_W-1:0]   s_eff;
  logic [ST_W-1:0]   nxt;
  logic              ok;

  // Without overlap a completed match restarts the search from empty.
  assign s_eff = (state == FULL && !OVERLAP) ? '0 : state;

  // The transition is evaluated for each candidate state with constant
  // indices and the live one is then selected, so no variable bit-select of
  // the pattern is needed. For state sv, candidate k is valid when the last
  // k-1 matched bits (pt[sv-k+1 .. sv-1]) equal pt[0 .. k-2] and In_Data
  // equals pt[k-1]; the largest valid k wins.
  always_comb begin
    ok = 1'b0;
    for (int unsigned i = 0; i < N_BITS; i++) begin
      pt[i] = pat_reg[N_BITS-1-i];
    end
    for (int unsigned sv = 0; sv <= N_BITS; sv++) begin
      kk[sv] = '0;
      for (int unsigned k = 1; k <= N_BITS; k++) begin
        if (k <= sv + 1) begin
          ok = (pt[k-1] == In_Data);
          for (int unsigned j = 0; j + 1 < k; j++) begin
            if (pt[sv + 1 - k + j] != pt[j]) begin
              ok = 1'b0;
            end
          end
          if (ok) begin
            kk[sv] = ST_W'(k);
          end
        end
      end
    end
    nxt = kk[s_eff];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= '0;
      match_r <= 1'b0;
      pat_reg <= PAT_DEFAULT;
      cnt     <= '0;
    end else begin
      if (Load_Pattern) begin
        pat_reg <= Pattern;
        state   <= '0;
        match_r <= 1'b0;
      end else if (In_Valid) begin
        state   <= nxt;
        match_r <= (nxt == FULL);
      end

      if (Count_Clr) begin
        cnt <= '0;
      end else if (!Load_Pattern && In_Valid && nxt == FULL && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign Out_State   = state;
  assign Out_Match   = match_r;
  assign Match_Count = cnt;

endmodule

// File: tb/tb_moore_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_moore_pattern_detector
//
// Three detector instances share one stimulus stream:
//   u0: N_BITS=4, OVERLAP=1, CNT_W=8
//   u1: N_BITS=4, OVERLAP=0, CNT_W=8
//   u2: N_BITS=4, OVERLAP=1, CNT_W=2
// A history-based model (longest suffix of received bits that is a pattern
// prefix) is compared against every instance each cycle; directed literal
// expectations pin the model.
// ---------------------------------------------------------------------------
module tb_moore_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       In_Valid = 1'b0;
  logic       In_Data = 1'b0;
  logic       Load_Pattern = 1'b0;
  logic [3:0] Pattern = 4'b0000;
  logic       Count_Clr = 1'b0;

  logic [2:0] st0, st1, st2;
  logic       m0, m1, m2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  moore_pattern_detector #(.N_BITS(4), .PAT_DEFAULT(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .In_Valid(In_Valid), .In_Data(In_Data),
    .Load_Pattern(Load_Pattern), .Pattern(Pattern), .Count_Clr(Count_Clr),
    .Out_State(st0), .Out_Match(m0), .Match_Count(c0));

  moore_pattern_detector #(.N_BITS(4), .PAT_DEFAULT(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .In_Valid(In_Valid), .In_Data(In_Data),
    .Load_Pattern(Load_Pattern), .Pattern(Pattern), .Count_Clr(Count_Clr),
    .Out_State(st1), .Out_Match(m1), .Match_Count(c1));

  moore_pattern_detector #(.N_BITS(4), .PAT_DEFAULT(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .In_Valid(In_Valid), .In_Data(In_Data),
    .Load_Pattern(Load_Pattern), .Pattern(Pattern), .Count_Clr(Count_Clr),
    .Out_State(st2), .Out_Match(m2), .Match_Count(c2));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- model ----------------
  bit         live = 1'b0;
  logic [3:0] mpat [3];
  logic [3:0] mhv  [3];   // newest received bit at bit 0
  int         mhl  [3];   // number of meaningful history bits (<=4)
  int         mst  [3];
  int         mcnt [3];
  bit         ovl  [3] = '{1'b1, 1'b0, 1'b1};
  int         cmax [3] = '{255, 255, 3};

  // longest k such that the last k received bits equal the first k pattern bits
  function automatic int best(input logic [3:0] hv, input int hl, input logic [3:0] p);
    bit eq;
    for (int k = hl; k >= 1; k--) begin
      eq = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (((hv >> (k - 1 - i)) & 4'd1) != ((p >> (3 - i)) & 4'd1)) eq = 1'b0;
      end
      if (eq) return k;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    bit inc;
    for (int i = 0; i < 3; i++) begin
      inc = 1'b0;
      if (rst) begin
        mpat[i] = 4'b1011; mhv[i] = 4'b0000; mhl[i] = 0; mst[i] = 0; mcnt[i] = 0;
      end else begin
        if (Load_Pattern) begin
          mpat[i] = Pattern; mhl[i] = 0; mst[i] = 0;
        end else if (In_Valid) begin
          if (mst[i] == 4 && !ovl[i]) mhl[i] = 0;
          mhv[i] = {mhv[i][2:0], In_Data};
          mhl[i] = (mhl[i] < 4) ? mhl[i] + 1 : 4;
          mst[i] = best(mhv[i], mhl[i], mpat[i]);
          inc = (mst[i] == 4);
        end
        if (Count_Clr) mcnt[i] = 0;
        else if (inc && mcnt[i] < cmax[i]) mcnt[i]++;
      end
    end
    if (rst) live = 1'b1;
  end

  // per-cycle comparison of all instances against the model
  always @(posedge clk) begin
    #1;
    if (live) begin
      chk("u0.state", int'(st0), mst[0]);
      chk("u0.match", int'(m0), int'(mst[0] == 4));
      chk("u0.count", int'(c0), mcnt[0]);
      chk("u1.state", int'(st1), mst[1]);
      chk("u1.match", int'(m1), int'(mst[1] == 4));
      chk("u1.count", int'(c1), mcnt[1]);
      chk("u2.state", int'(st2), mst[2]);
      chk("u2.match", int'(m2), int'(mst[2] == 4));
      chk("u2.count", int'(c2), mcnt[2]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic lp, input logic v, input logic d, input logic cl);
    @(negedge clk);
    rst = r; Load_Pattern = lp; In_Valid = v; In_Data = d; Count_Clr = cl;
    @(posedge clk);
    #2;
  endtask

  task automatic bit_in(input logic d);
    step(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] s7;
    int exp0 [7];
    int exp1 [7];
    int exp4 [7];
    int exp5 [5];

    // reset
    do_reset();
    chk("rst.state", int'(st0), 0);
    chk("rst.match", int'(m0), 0);
    chk("rst.count", int'(c0), 0);

    // stream 1011011: overlap (u0) vs restart (u1)
    s7 = 7'b1011011;
    exp0 = '{1, 2, 3, 4, 2, 3, 4};
    exp1 = '{1, 2, 3, 4, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      bit_in(s7[6 - i]);
      chk("ovl.state", int'(st0), exp0[i]);
      chk("novl.state", int'(st1), exp1[i]);
      chk("ovl.match", int'(m0), int'(i == 3 || i == 6));
    end
    chk("ovl.count", int'(c0), 2);
    chk("novl.count", int'(c1), 1);

    // reset while matched and a valid bit is presented
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rstmid.state", int'(st0), 0);
    chk("rstmid.match", int'(m0), 0);
    chk("rstmid.count", int'(c0), 0);

    // valid gaps: 1,0, three idle cycles, 1,1
    exp4 = '{1, 2, 2, 2, 2, 3, 4};
    for (int i = 0; i < 7; i++) begin
      if (i >= 2 && i <= 4) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else bit_in((i == 1) ? 1'b0 : 1'b1);
      chk("gap.state", int'(st0), exp4[i]);
    end
    chk("gap.count", int'(c0), 1);

    // load while matched: match drops next cycle
    Pattern = 4'b1011;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ldmatch.match", int'(m0), 0);
    chk("ldmatch.state", int'(st0), 0);
    chk("ldmatch.count", int'(c0), 1);

    // load mid-stream at state 3 with a valid bit (bit ignored), then zeros
    do_reset();
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    chk("pre.state", int'(st0), 3);
    Pattern = 4'b0000;
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ld.state", int'(st0), 0);
    exp5 = '{1, 2, 3, 4, 4};
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b0);
      chk("zeros.state", int'(st0), exp5[i]);
    end
    chk("zeros.count", int'(c0), 2);

    // saturation with CNT_W=2, then clear on a completing edge
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_in(1'b0);
    chk("sat.count8", int'(c0), 5);
    chk("sat.count2", int'(c2), 3);
    chk("sat.novl", int'(c1), 2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr.count", int'(c2), 0);
    chk("clr.count8", int'(c0), 0);
    chk("clr.match", int'(m2), 1);

    // a few random valid bits to exercise the model cross-check
    Pattern = 4'b0110;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/moore_pattern_detector.md
Name: moore_pattern_detector

Overview:
Parametrised Moore-type serial pattern detector for the lab FSM family. It is the successor of the fixed 4-state, 1-bit-input Moore machine.
- Pattern length, the pattern itself (runtime-loadable), overlap mode and match-counter width are all configurable.
- State encodes "number of pattern bits currently matched". All outputs are functions of registered state only (Moore).
- Sits between a serial bit source and a status/counter readout.

Parameters:
N_BITS, 4, pattern length in bits (>=2); states 0..N_BITS
PAT_DEFAULT, 4'b1011, pattern loaded at reset (width N_BITS)
OVERLAP, 1, 1 = overlapping matches allowed, 0 = search restarts from empty after a match
CNT_W, 8, width of match counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
In_Valid  input  1  In_Data sampled this cycle
In_Data  input  1  serial input bit
Load_Pattern  input  1  load Pattern into internal pattern register
Pattern  input  N_BITS  new pattern, MSB = first bit in time
Count_Clr  input  1  clear match counter
Out_State  output  $clog2(N_BITS+1)  current state (bits matched)
Out_Match  output  1  high while state == N_BITS
Match_Count  output  CNT_W  number of matches, saturating

Behaviour:
- Reset (sync, rst=1 at edge): state=0, pattern reg=PAT_DEFAULT, Match_Count=0. Out_State=0 and Out_Match=0 from the next cycle. rst overrides all other inputs, including mid-match.
- Priority per edge: rst > Load_Pattern > In_Valid.
- Load_Pattern=1: pattern reg<=Pattern, state<=0; In_Data ignored that cycle; Match_Count unaffected.
- In_Valid=0 (no load): state holds.
- In_Valid=1, no load: let s = current state, or 0 if s==N_BITS and OVERLAP=0.
  - Form string w = first s pattern bits followed by In_Data.
  - next state = largest k <= min(s+1, N_BITS) such that the last k bits of w equal the first k pattern bits (KMP next-state). k=0 if none.
  - Computed combinationally in one cycle. No lookup table beyond the loaded pattern.
- State N_BITS with OVERLAP=1: next state follows the same rule on s=N_BITS (longest proper border plus new bit).
- Out_Match = (state == N_BITS). Latency: high in the cycle after the edge that sampled the completing bit.
- Out_State = state register, directly.
- Match_Count:
  - Increments on the edge where next state == N_BITS due to a valid bit.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Count_Clr=1 sets it to 0 and wins over a same-cycle increment.
- X/invalid Pattern is not checked. Pattern may be loaded at any time, including while Out_Match=1; Out_Match drops on the next cycle.

Test Plan:
1. Reset → rst high 2 cycles: Out_State=0, Out_Match=0, Match_Count=0, pattern=1011.
2. OVERLAP=1, N_BITS=4, pattern 1011, valid stream 1,0,1,1,0,1,1 → Out_State after each edge 1,2,3,4,2,3,4; Out_Match high after bits 4 and 7; Match_Count=2.
3. OVERLAP=0 instance, same stream → states 1,2,3,4,0,1,1; Match_Count=1.
4. In_Valid gaps → stream 1,0 with 3 idle cycles, then 1,1 → state holds at 2 during idle; reaches 4 after last bit; Match_Count=1.
5. Load_Pattern mid-stream (state=3) with Pattern=0000, In_Valid=1 same cycle → state=0, bit ignored. Then five 0s (OVERLAP=1) → states 1,2,3,4,4; Match_Count increments by 2.
6. CNT_W=2 → 5 matches: Match_Count=3 (saturated). Count_Clr asserted on a completing edge → Match_Count=0 next cycle, Out_Match=1.
